// File: rtl/do_tan_so.sv
`timescale 1ns/1ps
// do_tan_so: frequency meter for slow square waves. Counts synchronized clk_in
// rising edges over a GATE_CYCLES window and publishes the saturated count.
module do_tan_so #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic             en,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             ovf,
    output logic             busy
);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GATE = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Returns {saturated, next_count}; an edge arriving at full scale is lost.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        if (!inc) begin
            sat_inc = {1'b0, cnt};
        end else if (cnt == CNT_MAX) begin
            sat_inc = {1'b1, cnt};
        end else begin
            sat_inc = {1'b0, cnt + CNT_W'(1'b1)};
        end
    endfunction

    logic             s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;
    logic [1:0]       state_q, state_d;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             edge_s;
    logic             sat_s;
    logic [CNT_W-1:0] edge_nxt_s;

    assign edge_s = s2_q & ~s3_q;
    assign {sat_s, edge_nxt_s} = sat_inc(edge_cnt_q, edge_s);

    // Next-state logic for the synchronizer, gate FSM, counters and result.
    always_comb begin
        s1_d       = clk_in;
        s2_d       = s1_q;
        s3_d       = s2_q;
        state_d    = state_q;
        gate_cnt_d = {GW{1'b0}};
        edge_cnt_d = {CNT_W{1'b0}};
        ovf_acc_d  = 1'b0;
        freq_d     = freq_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        busy_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_GATE;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GATE: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (gate_cnt_q == GATE_LAST) begin
                    // Final window cycle: fold in this cycle's edge before publishing.
                    state_d = ST_DONE;
                    freq_d  = edge_nxt_s;
                    ovf_d   = ovf_acc_q | sat_s;
                    valid_d = 1'b1;
                end else begin
                    state_d    = ST_GATE;
                    gate_cnt_d = gate_cnt_q + GW'(1'b1);
                    edge_cnt_d = edge_nxt_s;
                    ovf_acc_d  = ovf_acc_q | sat_s;
                    busy_d     = 1'b1;
                end
            end
            ST_DONE: begin
                if (en) begin
                    state_d = ST_GATE;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            state_q    <= ST_IDLE;
            gate_cnt_q <= {GW{1'b0}};
            edge_cnt_q <= {CNT_W{1'b0}};
            ovf_acc_q  <= 1'b0;
            freq_q     <= {CNT_W{1'b0}};
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_acc_q  <= ovf_acc_d;
            freq_q     <= freq_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign freq       = freq_q;
    assign freq_valid = valid_q;
    assign ovf        = ovf_q;
    assign busy       = busy_q;
endmodule
